mdu_iter: RTL and testbench
===========================

# mdu_iter

Parametrised multiply/divide unit that owns the HI/LO architectural registers for the MIPS pipeline. It sits beside the ALU in the execute stage and replaces the single-width HI/LO path with one configurable block. The block provides a pipelined multiply, an iterative restoring divide, and MTHI/MTLO writes. A combinational `busy` drives the hazard unit's stall, and `flush` cancels in-flight work.

## Interface
Parameters:
- `WIDTH`, 32: operand, HI and LO width. Must be even and ≥ 4.
- `MUL_STAGES`, 2: multiply latency in cycles. Legal range 1..4.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: operation valid this cycle (execute stage).
- `op`  in  3: operation code. MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5. Codes 6 and 7 are ignored.
- `a`  in  WIDTH: rs value (dividend / multiplicand / MTHI-MTLO data).
- `b`  in  WIDTH: rt value.
- `flush`  in  1: cancel any in-flight or same-cycle operation.
- `busy`  out  1: combinational stall request.
- `done`  out  1: registered, one-cycle pulse when HI/LO is committed.
- `div_by_zero`  out  1: registered, pulses with `done` for a divide by zero.
- `hi`  out  WIDTH: HI register.
- `lo`  out  WIDTH: LO register.

## Operation
- States: IDLE, MUL, DIV. A cycle counter `cnt` (width clog2(WIDTH+1)) runs in both multi-cycle states.
- In IDLE, `start` with no `flush` is accepted. In any other state, `start` is ignored; the hazard unit holds the instruction.
- **MTHI/MTLO:** `hi` (or `lo`) takes `a` at the next edge. No busy cycle. `done` pulses the following cycle.
- **MULT/MULTU:** the 2·WIDTH product is formed from the operands captured at start, signed or unsigned. It passes through MUL_STAGES register stages; {hi,lo} takes the product on the last stage.
- **DIV/DIVU:**
  - Setup edge: capture |a| and |b| (raw values for DIVU) and the result signs.
  - Then WIDTH restoring shift-subtract iterations.
  - Final edge: sign-correct and write lo=quotient, hi=remainder.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Most-negative ÷ −1 gives lo=most-negative and hi=0, with no trap.
- **Divide by zero:** detected at start. hi and lo are unchanged. No iteration is performed. `done` and `div_by_zero` pulse the next cycle.
- **Busy:** `busy = (state != IDLE) | (start & ~flush & op∈{0..3} & ~(op∈{2,3} & b==0))`.
- **Flush:** `flush` in any state returns to IDLE at the next edge. No commit and no `done`. hi and lo are unchanged.
- **Reset:** `rst` at any time forces IDLE at the next edge. hi=lo=0, done=div_by_zero=0, busy=0, counter cleared. Reset has priority over flush, and flush has priority over start.

## Timing
- Cycle 0 is the cycle in which `start` is high and accepted.
- Multiply: `busy` is high in cycles 0..MUL_STAGES−1. hi/lo are valid and `done`=1 in cycle MUL_STAGES.
- Divide: `busy` is high in cycles 0..WIDTH (one setup cycle plus WIDTH iterations). hi/lo are valid and `done`=1 in cycle WIDTH+1.
- MTHI/MTLO and divide by zero: `busy`=0 for MTHI/MTLO; divide by zero is also non-busy per the busy equation in Operation. The write or flag occurs at the edge ending cycle 0, and `done` is high in cycle 1.
- A new `start` is accepted in the `done` cycle (back-to-back operation).
- In the `done` cycle, `hi`/`lo` already hold the new values.

## Structure
- Package `mdu_pkg` holds:
  - the `op` encoding constants;
  - the state enum (IDLE, MUL, DIV);
  - the function `is_multi(op)`.
- One sub-module, `div_restoring_core`, holds:
  - the iteration registers (remainder, quotient, divisor);
  - the counter;
  - a `last` flag.
- `mdu_iter` holds:
  - the FSM;
  - the sign capture and correction;
  - the multiply pipe, a shift chain of MUL_STAGES registers so synthesis can retime the multiplier;
  - the HI/LO registers.

## Test plan
All scenarios use WIDTH=32 and MUL_STAGES=2.
- MULT with a=0xFFFFFFFE, b=3 → busy in cycles 0–1; in cycle 2, done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU with a=0xFFFFFFFE, b=3 → hi=0x00000002, lo=0xFFFFFFFA in cycle 2.
- DIV with a=0xFFFFFFF9 (−7), b=2 → busy in cycles 0–32; in cycle 33, lo=0xFFFFFFFD, hi=0xFFFFFFFF. Separately, DIV with 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU with a=100, b=0, after an earlier MTLO 0x55 → busy=0; in cycle 1, done=1, div_by_zero=1, lo=0x55 unchanged.
- DIV started, then flush in cycle 10 → busy=0 in cycle 11, no done, hi/lo unchanged. Then MTHI with a=0x1234 in cycle 11 → hi=0x1234 in cycle 12.
- A completed MULT, then DIVU started with rst in cycle 5 → in cycle 6, hi=lo=0, busy=0, done=0. A new DIVU 9/4 then gives lo=2, hi=1.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM states and op-class helpers for the multiply/divide unit
package mdu_pkg;
   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;
   function automatic logic is_multi(input logic [2:0] op);
      return op <= OP_DIVU;
   endfunction
   function automatic logic is_div(input logic [2:0] op);
      return op[2:1] == 2'b01;
   endfunction
endpackage

// File: rtl/div_restoring_core.sv
// div_restoring_core: unsigned restoring shift-subtract divider with shared cycle counter
// ports: load_i seeds operands and clears cnt; step_i runs one iteration and bumps cnt;
//        quo_o/rem_o are the post-iteration values, so the final step can be committed directly;
//        cnt_o is the counter, last_o flags the final iteration
module div_restoring_core
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] quo_o,
   output logic [WIDTH-1:0] rem_o,
   output logic [CW-1:0]    cnt_o,
   output logic             last_o
);
   logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH:0]   trial, diff;
   // remainder stays below the divisor, so the shifted trial fits in WIDTH+1 bits and the top bit of diff is the borrow
   assign trial  = {rem_q, quo_q[WIDTH-1]};
   assign diff   = trial - {1'b0, dvs_q};
   assign rem_o  = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
   assign quo_o  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
   assign cnt_o  = cnt_q;
   assign last_o = cnt_q == CW'(WIDTH - 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else if (load_i) begin
         rem_q <= '0;
         quo_q <= dividend_i;
         dvs_q <= divisor_i;
         cnt_q <= '0;
      end else if (step_i) begin
         rem_q <= rem_o;
         quo_q <= quo_o;
         cnt_q <= cnt_q + 1'b1;
      end
   end
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: HI/LO owner with pipelined multiply, iterative divide and MTHI/MTLO
// ports: start_i/op_i/a_i/b_i issue an op from execute; flush_i cancels; busy_o stalls the pipe;
//        done_o pulses on commit, div_by_zero_o pulses with it for b==0 divides; hi_o/lo_o are HI/LO
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_by_zero_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] MUL_LAST = CW'(MUL_STAGES > 1 ? MUL_STAGES - 2 : 0);
   state_e             state_q, state_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, quo, rem, a_mag, b_mag;
   logic               done_q, done_d, dbz_q, dbz_d, qneg_q, qneg_d, rneg_q, rneg_d;
   logic               load, step, last, sx, a_neg, b_neg, b_zero;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] prod, mul_res;
   // even op codes (MULT, DIV) are the signed variants
   assign sx     = ~op_i[0];
   assign a_neg  = sx & a_i[WIDTH-1];
   assign b_neg  = sx & b_i[WIDTH-1];
   assign a_mag  = a_neg ? -a_i : a_i;
   assign b_mag  = b_neg ? -b_i : b_i;
   assign b_zero = b_i == '0;
   assign prod   = {{WIDTH{a_neg}}, a_i} * {{WIDTH{b_neg}}, b_i};
   assign busy_o = state_q != S_IDLE ||
                   (start_i && !flush_i && is_multi(op_i) && !(is_div(op_i) && b_zero));
   assign done_o        = done_q;
   assign div_by_zero_o = dbz_q;
   assign hi_o          = hi_q;
   assign lo_o          = lo_q;
   // HI/LO is the last multiply stage, so the chain holds MUL_STAGES-1 registers
   generate
      if (MUL_STAGES == 1) begin : g_comb
         assign mul_res = prod;
      end else begin : g_pipe
         logic [2*WIDTH-1:0] pipe_q [MUL_STAGES-1];
         always_ff @(posedge clk) begin
            pipe_q[0] <= prod;
            for (int i = 1; i < MUL_STAGES - 1; i++) pipe_q[i] <= pipe_q[i-1];
         end
         assign mul_res = pipe_q[MUL_STAGES-2];
      end
   endgenerate
   div_restoring_core #(.WIDTH(WIDTH), .CW(CW)) u_div (
      .clk       (clk),
      .rst       (rst),
      .load_i    (load),
      .step_i    (step),
      .dividend_i(a_mag),
      .divisor_i (b_mag),
      .quo_o     (quo),
      .rem_o     (rem),
      .cnt_o     (cnt),
      .last_o    (last)
   );
   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dbz_d   = 1'b0;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      load    = 1'b0;
      step    = 1'b0;
      if (flush_i) state_d = S_IDLE;
      else begin
         case (state_q)
            S_IDLE: if (start_i) begin
               if (op_i == OP_MTHI || op_i == OP_MTLO) begin
                  hi_d   = op_i == OP_MTHI ? a_i : hi_q;
                  lo_d   = op_i == OP_MTLO ? a_i : lo_q;
                  done_d = 1'b1;
               end else if (is_div(op_i) && b_zero) begin
                  done_d = 1'b1;
                  dbz_d  = 1'b1;
               end else if (is_div(op_i)) begin
                  state_d = S_DIV;
                  load    = 1'b1;
                  qneg_d  = a_neg ^ b_neg;
                  rneg_d  = a_neg;
               end else if (is_multi(op_i)) begin
                  if (MUL_STAGES == 1) begin
                     {hi_d, lo_d} = prod;
                     done_d       = 1'b1;
                  end else begin
                     state_d = S_MUL;
                     load    = 1'b1;
                  end
               end
            end
            // the divider counter doubles as the multiply stage counter; its datapath is idle here
            S_MUL: begin
               step = 1'b1;
               if (cnt == MUL_LAST) begin
                  {hi_d, lo_d} = mul_res;
                  done_d       = 1'b1;
                  state_d      = S_IDLE;
               end
            end
            S_DIV: begin
               step = 1'b1;
               if (last) begin
                  lo_d    = qneg_q ? -quo : quo;
                  hi_d    = rneg_q ? -rem : rem;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
      end
   end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: randomized and directed checks of mdu_iter against an arithmetic HI/LO model
module tb_mdu_iter;
   localparam int W = 32;
   logic         clk = 1'b0;
   logic         rst, start, flush;
   logic [2:0]   op;
   logic [W-1:0] a, b;
   logic         busy, done, dbz;
   logic [W-1:0] hi, lo;
   logic [W-1:0] m_hi, m_lo;
   int           total = 0;
   int           bad = 0;

   mdu_iter #(.WIDTH(W), .MUL_STAGES(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start),
      .op_i         (op),
      .a_i          (a),
      .b_i          (b),
      .flush_i      (flush),
      .busy_o       (busy),
      .done_o       (done),
      .div_by_zero_o(dbz),
      .hi_o         (hi),
      .lo_o         (lo)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // drive one start cycle (cycle 0), return busy seen in it; leaves time inside cycle 1
   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output logic busy0);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      #1;
      busy0 = busy;
      @(posedge clk);
      #1;
      start = 1'b0;
      #1;
   endtask

   // returns the cycle index where done is seen (-1 on timeout) and whether busy dropped before it
   task automatic wait_done(output int cyc, output logic gap);
      cyc = 1;
      gap = 1'b0;
      while (!done && cyc < 100) begin
         if (!busy) gap = 1'b1;
         tick();
         cyc++;
      end
      if (!done) cyc = -1;
   endtask

   // architectural behaviour: updates m_hi/m_lo, returns done cycle (0 = never) and the div-by-zero flag
   task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int cyc, output logic z);
      longint sa, sb, r;
      sa = longint'($signed(x));
      sb = longint'($signed(y));
      z  = 1'b0;
      cyc = 0;
      case (o)
         3'd0: begin r = sa * sb; {m_hi, m_lo} = r; cyc = 2; end
         3'd1: begin {m_hi, m_lo} = {32'b0, x} * {32'b0, y}; cyc = 2; end
         3'd2: if (y == 0) begin z = 1'b1; cyc = 1; end
               else begin r = sa / sb; m_lo = r[31:0]; r = sa % sb; m_hi = r[31:0]; cyc = 33; end
         3'd3: if (y == 0) begin z = 1'b1; cyc = 1; end
               else begin m_lo = x / y; m_hi = x % y; cyc = 33; end
         3'd4: begin m_hi = x; cyc = 1; end
         3'd5: begin m_lo = x; cyc = 1; end
         default: cyc = 0;
      endcase
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 300));
         default: return $urandom;
      endcase
   endfunction

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) tick();
      rst = 1'b0;
      #1;
      m_hi = '0;
      m_lo = '0;
      total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi, lo); end
      total++; if (done !== 1'b0 || dbz !== 1'b0) begin bad++; $display("FAIL reset_flags got done=%b dbz=%b exp=0/0", done, dbz); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
   endtask

   task automatic test_vectors;
      logic [2:0]   t_op [5] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3};
      logic [W-1:0] t_a  [5] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'h80000000, 32'd9};
      logic [W-1:0] t_b  [5] = '{32'd3, 32'd3, 32'd2, 32'hFFFFFFFF, 32'd4};
      logic [W-1:0] t_hi [5] = '{32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'h0, 32'd1};
      logic [W-1:0] t_lo [5] = '{32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFFD, 32'h80000000, 32'd2};
      int           t_c  [5] = '{2, 2, 33, 33, 33};
      logic b0, gap;
      int cyc;
      for (int i = 0; i < 5; i++) begin
         issue(t_op[i], t_a[i], t_b[i], b0);
         wait_done(cyc, gap);
         m_hi = t_hi[i];
         m_lo = t_lo[i];
         total++; if (b0 !== 1'b1) begin bad++; $display("FAIL vec%0d_busy0 got=%b exp=1", i, b0); end
         total++; if (cyc !== t_c[i] || gap !== 1'b0) begin bad++; $display("FAIL vec%0d_timing got cyc=%0d gap=%b exp cyc=%0d gap=0", i, cyc, gap, t_c[i]); end
         total++; if (hi !== t_hi[i] || lo !== t_lo[i]) begin bad++; $display("FAIL vec%0d_result got=%h/%h exp=%h/%h", i, hi, lo, t_hi[i], t_lo[i]); end
         total++; if (dbz !== 1'b0) begin bad++; $display("FAIL vec%0d_dbz got=%b exp=0", i, dbz); end
      end
   endtask

   task automatic test_div_zero;
      logic b0, gap;
      int cyc;
      issue(3'd5, 32'h55, 32'h0, b0);
      wait_done(cyc, gap);
      m_lo = 32'h55;
      total++; if (b0 !== 1'b0 || cyc !== 1 || lo !== 32'h55) begin bad++; $display("FAIL mtlo got busy0=%b cyc=%0d lo=%h exp 0/1/55", b0, cyc, lo); end
      tick();
      issue(3'd3, 32'd100, 32'd0, b0);
      total++; if (b0 !== 1'b0) begin bad++; $display("FAIL dz_busy got=%b exp=0", b0); end
      total++; if (done !== 1'b1 || dbz !== 1'b1) begin bad++; $display("FAIL dz_flags got done=%b dbz=%b exp=1/1", done, dbz); end
      total++; if (hi !== m_hi || lo !== 32'h55) begin bad++; $display("FAIL dz_hilo got=%h/%h exp=%h/00000055", hi, lo, m_hi); end
      tick();
      total++; if (done !== 1'b0 || dbz !== 1'b0) begin bad++; $display("FAIL dz_pulse got done=%b dbz=%b exp=0/0", done, dbz); end
   endtask

   task automatic test_flush;
      logic b0;
      issue(3'd2, $urandom, 32'd7, b0);
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL flush_state got busy=%b done=%b exp=0/0", busy, done); end
      total++; if (hi !== m_hi || lo !== m_lo) begin bad++; $display("FAIL flush_hilo got=%h/%h exp=%h/%h", hi, lo, m_hi, m_lo); end
      issue(3'd4, 32'h1234, 32'h0, b0);
      m_hi = 32'h1234;
      total++; if (b0 !== 1'b0 || done !== 1'b1 || hi !== 32'h1234) begin bad++; $display("FAIL mthi got busy0=%b done=%b hi=%h exp 0/1/1234", b0, done, hi); end
      tick();
      start = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_start_busy got=%b exp=0", busy); end
      tick();
      start = 1'b0; flush = 1'b0;
      repeat (3) tick();
      total++; if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin bad++; $display("FAIL flush_start got busy=%b done=%b hilo=%h/%h exp 0/0 %h/%h", busy, done, hi, lo, m_hi, m_lo); end
   endtask

   task automatic test_reset_mid;
      logic b0, gap, z;
      int cyc, ecyc;
      model(3'd0, 32'd1000, 32'hFFFFFFF0, ecyc, z);
      issue(3'd0, 32'd1000, 32'hFFFFFFF0, b0);
      wait_done(cyc, gap);
      total++; if (hi !== m_hi || lo !== m_lo) begin bad++; $display("FAIL rm_mult got=%h/%h exp=%h/%h", hi, lo, m_hi, m_lo); end
      tick();
      issue(3'd3, 32'd77, 32'd5, b0);
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      m_hi = '0;
      m_lo = '0;
      total++; if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rm_reset got hilo=%h/%h busy=%b done=%b exp 0/0 0 0", hi, lo, busy, done); end
      model(3'd3, 32'd9, 32'd4, ecyc, z);
      issue(3'd3, 32'd9, 32'd4, b0);
      wait_done(cyc, gap);
      total++; if (cyc !== ecyc || hi !== 32'd1 || lo !== 32'd2) begin bad++; $display("FAIL rm_divu got cyc=%0d hilo=%h/%h exp %0d 1/2", cyc, hi, lo, ecyc); end
   endtask

   task automatic test_back_to_back;
      logic b0, gap, z;
      int cyc, ecyc;
      logic [W-1:0] x, y;
      x = $urandom; y = $urandom;
      model(3'd0, x, y, ecyc, z);
      issue(3'd0, x, y, b0);
      wait_done(cyc, gap);
      x = $urandom; y = $urandom;
      model(3'd1, x, y, ecyc, z);
      issue(3'd1, x, y, b0);
      total++; if (b0 !== 1'b1) begin bad++; $display("FAIL b2b_accept got busy0=%b exp=1", b0); end
      wait_done(cyc, gap);
      total++; if (cyc !== ecyc || hi !== m_hi || lo !== m_lo) begin bad++; $display("FAIL b2b_result got cyc=%0d %h/%h exp %0d %h/%h", cyc, hi, lo, ecyc, m_hi, m_lo); end
   endtask

   task automatic test_random;
      logic [2:0] o;
      logic [W-1:0] x, y;
      logic b0, gap, z;
      int cyc, ecyc;
      for (int n = 0; n < 40; n++) begin
         o = 3'($urandom_range(0, 7));
         x = pick();
         y = pick();
         if ((o == 3'd2 || o == 3'd3) && $urandom_range(0, 3) == 0) y = '0;
         model(o, x, y, ecyc, z);
         issue(o, x, y, b0);
         total++; if (b0 !== (ecyc > 1)) begin bad++; $display("FAIL rnd%0d_busy0 op=%0d got=%b exp=%b", n, o, b0, ecyc > 1); end
         if (ecyc == 0) begin
            total++; if (done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin bad++; $display("FAIL rnd%0d_ignored op=%0d got done=%b %h/%h exp 0 %h/%h", n, o, done, hi, lo, m_hi, m_lo); end
         end else begin
            wait_done(cyc, gap);
            total++; if (cyc !== ecyc || gap !== 1'b0) begin bad++; $display("FAIL rnd%0d_timing op=%0d got cyc=%0d gap=%b exp %0d 0", n, o, cyc, gap, ecyc); end
            total++; if (hi !== m_hi || lo !== m_lo || dbz !== z) begin bad++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got %h/%h dbz=%b exp %h/%h dbz=%b", n, o, x, y, hi, lo, dbz, m_hi, m_lo, z); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_div_zero();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
